// File: rtl/sysid_reader_pkg.sv
// Shared types and constants for the system-ID reader.
package sysid_reader_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRdId = 2'd1,
    StRdTs = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [31:0] SYSID_ID_OFS = 32'h0;
  localparam logic [31:0] SYSID_TS_OFS = 32'h4;

  localparam int unsigned CtrWidth = 16;

  function automatic logic is_read_state(input state_e s);
    return (s == StRdId) || (s == StRdTs);
  endfunction

endpackage

// File: rtl/sysid_reader_if.sv
// Avalon-MM read-only master/slave signal bundle.
interface sysid_reader_if;

  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/sysid_timeout_ctr.sv
// Stall counter for bus-probe masters: counts enabled cycles, flags the last allowed one.
module sysid_timeout_ctr #(
  parameter int unsigned Width = 16,
  parameter int unsigned Limit = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [Width-1:0] count,
  output logic             expire
);

  localparam logic [Width-1:0] LastCount = Width'(Limit - 1);
  localparam logic [Width-1:0] One       = Width'(1);

  // Clear has priority so a fresh read always starts counting from zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + One;
    end
  end

  assign expire = enable && (count == LastCount);

endmodule

// File: rtl/sysid_reader.sv
// Reads the sysid ID word and build timestamp, compares them with the expected
// values and reports match/timeout results for the boot logic.
module sysid_reader
  import sysid_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID    = 32'd896765832,
  parameter logic [31:0] EXPECTED_TS    = 32'd1309468710,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  sysid_reader_if.master        avm,
  output logic                  busy,
  output logic                  done,
  output logic                  id_match,
  output logic                  ts_match,
  output logic                  timeout,
  output logic [31:0]           id_value,
  output logic [31:0]           ts_value
);

  state_e        state_q;
  logic          read_q;
  logic [31:0]   address_q;
  logic          busy_q;
  logic          done_q;
  logic          id_match_q;
  logic          ts_match_q;
  logic          timeout_q;
  logic [31:0]   id_value_q;
  logic [31:0]   ts_value_q;
  logic          auto_pending_q;

  logic                in_read;
  logic                stall;
  logic                accept;
  logic                ctr_clear;
  logic                expire;
  logic [CtrWidth-1:0] stall_count;

  // Handshake qualifiers; acceptance (waitrequest low) is never a stall, so it beats timeout.
  always_comb begin
    in_read   = is_read_state(state_q);
    stall     = in_read && avm.avm_waitrequest;
    accept    = in_read && !avm.avm_waitrequest;
    ctr_clear = !in_read || accept;
  end

  sysid_timeout_ctr #(
    .Width (CtrWidth),
    .Limit (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (ctr_clear),
    .enable (stall),
    .count  (stall_count),
    .expire (expire)
  );

  // Main FSM with all outputs registered so the bus strobes are glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      read_q         <= 1'b0;
      address_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      id_match_q     <= 1'b0;
      ts_match_q     <= 1'b0;
      timeout_q      <= 1'b0;
      id_value_q     <= '0;
      ts_value_q     <= '0;
      auto_pending_q <= AUTO_START;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start || auto_pending_q) begin
            state_q        <= StRdId;
            read_q         <= 1'b1;
            address_q      <= BASE_ADDR + SYSID_ID_OFS;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            id_match_q     <= 1'b0;
            ts_match_q     <= 1'b0;
            timeout_q      <= 1'b0;
            id_value_q     <= '0;
            ts_value_q     <= '0;
            auto_pending_q <= 1'b0;
          end
        end
        StRdId: begin
          if (accept) begin
            // Go straight to the timestamp read without an idle cycle.
            id_value_q <= avm.avm_readdata;
            address_q  <= BASE_ADDR + SYSID_TS_OFS;
            state_q    <= StRdTs;
          end else if (expire) begin
            state_q    <= StDone;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
          end
        end
        StRdTs: begin
          if (accept) begin
            ts_value_q <= avm.avm_readdata;
            state_q    <= StDone;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            id_match_q <= (id_value_q == EXPECTED_ID);
            ts_match_q <= (avm.avm_readdata == EXPECTED_TS);
          end else if (expire) begin
            state_q    <= StDone;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The count value itself is only observed through expire.
  logic unused_count;
  assign unused_count = ^stall_count;

  assign avm.avm_read    = read_q;
  assign avm.avm_address = address_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_match        = id_match_q;
  assign ts_match        = ts_match_q;
  assign timeout         = timeout_q;
  assign id_value        = id_value_q;
  assign ts_value        = ts_value_q;

endmodule

// File: tb/tb_sysid_reader.sv
// Directed bench for sysid_reader: scripted slave, vector table plus corner sequences.
module tb_sysid_reader;

  localparam logic [31:0] ExpId  = 32'd896765832;
  localparam logic [31:0] ExpTs  = 32'd1309468710;
  localparam int          Budget = 40;

  typedef struct {
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int unsigned stall;
    bit          stuck;
    int          id_cycles;
    int          done_cyc;
    logic [31:0] e_id;
    logic [31:0] e_ts;
    bit          e_idm;
    bit          e_tsm;
    bit          e_to;
  } vec_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        id_match;
  logic        ts_match;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  logic [31:0] id_word    = ExpId;
  logic [31:0] ts_word    = ExpTs;
  int unsigned stall_cfg  = 0;
  bit          stuck_ts   = 1'b0;
  int unsigned stall_seen = 0;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[7];

  sysid_reader_if avm ();

  sysid_reader #(
    .BASE_ADDR      (32'h0000_0000),
    .EXPECTED_ID    (ExpId),
    .EXPECTED_TS    (ExpTs),
    .TIMEOUT_CYCLES (8),
    .AUTO_START     (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .avm      (avm),
    .busy     (busy),
    .done     (done),
    .id_match (id_match),
    .ts_match (ts_match),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clk = ~clk;

  // Slave: stalls each read for stall_cfg cycles; optionally never accepts the TS read.
  assign avm.avm_readdata    = (avm.avm_address == 32'h4) ? ts_word : id_word;
  assign avm.avm_waitrequest = avm.avm_read &&
                               ((stall_seen < stall_cfg) || (stuck_ts && avm.avm_address == 32'h4));

  always @(posedge clk) begin
    if (!avm.avm_read || !avm.avm_waitrequest) stall_seen <= 0;
    else stall_seen <= stall_seen + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at cycle 0 (just after an edge); counts cycles to done and checks the
  // bus handshake in every busy cycle. poke>0 pulses start during that cycle.
  task automatic wait_done(input int id_cycles, input int poke, output int dc, output int hb);
    int c = 1;
    dc = -1;
    hb = 0;
    @(posedge clk); #1;
    start = (poke == 1);
    while (c < Budget && dc < 0) begin
      @(negedge clk);
      if (done) begin
        dc = c;
      end else begin
        if (!busy || !avm.avm_read ||
            avm.avm_address != ((c <= id_cycles) ? 32'h0 : 32'h4)) hb++;
        @(posedge clk); #1;
        start = (c + 1 == poke);
        c++;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t v, input int dc, input int hb);
    check($sformatf("%s done_cycle", tag), dc, v.done_cyc);
    check($sformatf("%s handshake_bad_cycles", tag), hb, 0);
    check($sformatf("%s id_value", tag), id_value, v.e_id);
    check($sformatf("%s ts_value", tag), ts_value, v.e_ts);
    check($sformatf("%s id_match", tag), {31'b0, id_match}, {31'b0, v.e_idm});
    check($sformatf("%s ts_match", tag), {31'b0, ts_match}, {31'b0, v.e_tsm});
    check($sformatf("%s timeout", tag), {31'b0, timeout}, {31'b0, v.e_to});
    check($sformatf("%s idle_bus", tag), {30'b0, avm.avm_read, busy}, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s read", tag), {31'b0, avm.avm_read}, 32'h0);
    check($sformatf("%s address", tag), avm.avm_address, 32'h0);
    check($sformatf("%s busy_done", tag), {30'b0, busy, done}, 32'h0);
    check($sformatf("%s flags", tag), {29'b0, id_match, ts_match, timeout}, 32'h0);
    check($sformatf("%s id_value", tag), id_value, 32'h0);
    check($sformatf("%s ts_value", tag), ts_value, 32'h0);
  endtask

  initial begin
    int   dc;
    int   hb;
    int   stray;
    vec_t v;

    //          id_word       ts_word        stall stk idc done e_id   e_ts           idm tsm to
    vecs[0] = '{ExpId,        ExpTs,         0,    0,  1,  3,   ExpId, ExpTs,         1,  1,  0};
    vecs[1] = '{32'hDEADBEEF, ExpTs,         0,    0,  1,  3,   32'hDEADBEEF, ExpTs,  0,  1,  0};
    vecs[2] = '{ExpId,        ExpTs,         3,    0,  4,  9,   ExpId, ExpTs,         1,  1,  0};
    vecs[3] = '{ExpId,        ExpTs,         0,    1,  1,  10,  ExpId, 32'h0,         0,  0,  1};
    vecs[4] = '{ExpId,        32'h12345678,  1,    0,  2,  5,   ExpId, 32'h12345678,  1,  0,  0};
    vecs[5] = '{ExpId,        ExpTs,         7,    0,  8,  17,  ExpId, ExpTs,         1,  1,  0};
    vecs[6] = '{ExpId,        ExpTs,         8,    0,  8,  9,   32'h0, 32'h0,         0,  0,  1};

    // Reset state, then the automatic check after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    wait_done(1, 0, dc, hb);
    check_result("auto", vecs[0], dc, hb);

    // Table: each entry restarts the check from DONE.
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      @(posedge clk); #1;
      id_word   = v.id_word;
      ts_word   = v.ts_word;
      stall_cfg = v.stall;
      stuck_ts  = v.stuck;
      start     = 1'b1;
      wait_done(v.id_cycles, 0, dc, hb);
      check_result($sformatf("vec%0d", i), v, dc, hb);
    end

    // start while busy is ignored, and no restart happens afterwards.
    @(posedge clk); #1;
    id_word   = ExpId;
    ts_word   = ExpTs;
    stall_cfg = 3;
    stuck_ts  = 1'b0;
    start     = 1'b1;
    wait_done(4, 3, dc, hb);
    check_result("start_busy", vecs[2], dc, hb);
    stray = 0;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!done || busy || avm.avm_read) stray++;
    end
    check("start_busy no_restart", stray, 0);

    // Reset in the middle of a stalled TS read.
    @(posedge clk); #1;
    stall_cfg = 0;
    stuck_ts  = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midreset pre read", {31'b0, avm.avm_read}, 32'h1);
    check("midreset pre address", avm.avm_address, 32'h4);
    check("midreset pre id_value", id_value, ExpId);
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    stuck_ts = 1'b0;
    reset    = 1'b0;
    wait_done(1, 0, dc, hb);
    check_result("post_reset_auto", vecs[0], dc, hb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
